// File: rtl/dcache_direct_if.sv
// Bus bundle between the memory stage, the direct-mapped data cache and the
// memory controller. The cache owns the slave view; the environment (memory
// stage plus memory controller) owns the master view.
interface dcache_direct_if #(
  parameter int WORD_W = 32
);
  // memory stage request side
  logic              dcache_dREN;
  logic              dcache_dWEN;
  logic [WORD_W-1:0] dcache_daddr;
  logic [WORD_W-1:0] dcache_store;
  logic              halt;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;
  logic              flushed;
  // memory controller side
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  modport slave (
    input  dcache_dREN, dcache_dWEN, dcache_daddr, dcache_store, halt, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dcache_dREN, dcache_dWEN, dcache_daddr, dcache_store, halt, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_direct.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Hits are answered combinationally in IDLE; misses walk an optional
// writeback (WB) and then a line fill (FILL). Halt flushes every dirty line
// in index order and then parks in FLUSHED until reset.
module dcache_direct #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input logic           CLK,
  input logic           RST,
  dcache_direct_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    FILL    = 3'd2,
    FLUSH   = 3'd3,
    FLUSHED = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [WORD_W-1:0] data_mem [SETS];
  logic [IDX_W-1:0]  scan;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              req;
  logic              hit;
  logic              victim_dirty;
  logic              scan_dirty;
  logic              xfer_done;
  logic              scan_step;
  logic              unused_byte_bits;

  logic              hit_out;
  logic [WORD_W-1:0] load_data;
  logic              flush_done;
  logic              mem_ren;
  logic              mem_wen;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  assign idx              = bus.dcache_daddr[IDX_W+1:2];
  assign tag              = bus.dcache_daddr[WORD_W-1:IDX_W+2];
  assign unused_byte_bits = ^bus.dcache_daddr[1:0];
  assign req              = bus.dcache_dREN | bus.dcache_dWEN;
  assign hit              = (state == IDLE) && req && valid[idx] && (tag_mem[idx] == tag);
  assign victim_dirty     = valid[idx] & dirty[idx];
  assign scan_dirty       = valid[scan] & dirty[scan];
  assign xfer_done        = ~bus.dwait;
  // a clean line is skipped in one cycle, a dirty one waits for its writeback
  assign scan_step        = (state == FLUSH) && (!scan_dirty || xfer_done);

  // state register; reset abandons any transfer at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state decode; a pending request always wins over halt
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          if (victim_dirty) begin
            next_state = WB;
          end else begin
            next_state = FILL;
          end
        end else if (bus.halt && !req) begin
          next_state = FLUSH;
        end else begin
          next_state = IDLE;
        end
      end
      WB: begin
        if (xfer_done) begin
          next_state = FILL;
        end else begin
          next_state = WB;
        end
      end
      FILL: begin
        if (xfer_done) begin
          next_state = IDLE;
        end else begin
          next_state = FILL;
        end
      end
      FLUSH: begin
        if (scan_step && (scan == LAST_IDX)) begin
          next_state = FLUSHED;
        end else begin
          next_state = FLUSH;
        end
      end
      FLUSHED: next_state = FLUSHED;
      default: next_state = IDLE;
    endcase
  end

  // line status bits and flush scan pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= {SETS{1'b0}};
      dirty <= {SETS{1'b0}};
      scan  <= {IDX_W{1'b0}};
    end else begin
      if (hit && bus.dcache_dWEN) begin
        dirty[idx] <= 1'b1;
      end
      if ((state == WB) && xfer_done) begin
        dirty[idx] <= 1'b0;
      end
      if ((state == FILL) && xfer_done) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if ((state == FLUSH) && scan_dirty && xfer_done) begin
        dirty[scan] <= 1'b0;
      end
      if (scan_step) begin
        scan <= scan + IDX_ONE;
      end
    end
  end

  // tag and data arrays; contents are qualified by the valid bits only
  always_ff @(posedge CLK) begin
    if (hit && bus.dcache_dWEN) begin
      data_mem[idx] <= bus.dcache_store;
    end else if ((state == FILL) && xfer_done) begin
      data_mem[idx] <= bus.dload;
      tag_mem[idx]  <= tag;
    end
  end

  // per-state outputs; memory side stays quiet outside WB, FILL and flush writebacks
  always_comb begin
    hit_out    = hit;
    load_data  = {WORD_W{1'b0}};
    flush_done = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = {WORD_W{1'b0}};
    mem_wdata  = {WORD_W{1'b0}};
    case (state)
      IDLE: begin
        if (hit && !bus.dcache_dWEN) begin
          load_data = data_mem[idx];
        end else begin
          load_data = {WORD_W{1'b0}};
        end
      end
      WB: begin
        mem_wen   = 1'b1;
        mem_addr  = {tag_mem[idx], idx, 2'b00};
        mem_wdata = data_mem[idx];
      end
      FILL: begin
        mem_ren  = 1'b1;
        mem_addr = {tag, idx, 2'b00};
      end
      FLUSH: begin
        if (scan_dirty) begin
          mem_wen   = 1'b1;
          mem_addr  = {tag_mem[scan], scan, 2'b00};
          mem_wdata = data_mem[scan];
        end else begin
          mem_wen   = 1'b0;
        end
      end
      FLUSHED: flush_done = 1'b1;
      default: flush_done = 1'b0;
    endcase
  end

  assign bus.dhit     = hit_out;
  assign bus.dmemload = load_data;
  assign bus.flushed  = flush_done;
  assign bus.dREN     = mem_ren;
  assign bus.dWEN     = mem_wen;
  assign bus.daddr    = mem_addr;
  assign bus.dstore   = mem_wdata;
endmodule

// File: tb/tb_dcache_direct.sv
// Bench for dcache_direct: directed scenarios plus a random access mix,
// checked against a flat architectural memory image and a line-presence model.
module tb_dcache_direct;
  logic clk = 1'b1;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dcache_direct_if #(.WORD_W(32)) bus ();

  dcache_direct #(.SETS(16), .WORD_W(32)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wb_t;

  logic [31:0] mem    [logic [31:0]];   // backing memory behind the cache
  logic [31:0] golden [logic [31:0]];   // what a load must return
  wb_t         wb_log [$];
  int          wait_cycles = 0;
  int          cnt = 0;
  bit          started = 1'b0;
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [25:0] m_tag   [16];

  function automatic logic [31:0] mem_init(logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else return mem_init(a);
  endfunction

  function automatic logic [31:0] gold_rd(logic [31:0] a);
    if (golden.exists(a)) return golden[a];
    else return mem_init(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // memory controller: each transfer waits wait_cycles before dwait drops
  always @(negedge clk) begin
    if (bus.dREN || bus.dWEN) begin
      if (!started || !bus.dwait) begin
        cnt = wait_cycles;
        started = 1'b1;
      end
      if (cnt > 0) begin
        bus.dwait = 1'b1;
        bus.dload = 32'h0;
        cnt--;
      end else begin
        bus.dwait = 1'b0;
        bus.dload = bus.dREN ? mem_rd(bus.daddr) : 32'h0;
      end
    end else begin
      started = 1'b0;
      bus.dwait = 1'b1;
      bus.dload = 32'h0;
    end
  end

  // memory controller: commit writes and log them in order
  always @(posedge clk) begin
    if (!rst && bus.dWEN && !bus.dwait) begin
      mem[bus.daddr] = bus.dstore;
      wb_log.push_back('{a: bus.daddr, d: bus.dstore});
    end
  end

  // bus invariants sampled every cycle
  always @(negedge clk) begin
    if (!rst) begin
      check("mem_excl", {31'h0, bus.dREN & bus.dWEN}, 32'h0);
      if (!bus.dREN && !bus.dWEN) check("mem_quiet", bus.daddr | bus.dstore, 32'h0);
      else check("daddr_align", {30'h0, bus.daddr[1:0]}, 32'h0);
      if (!bus.dhit) check("dmemload_nohit", bus.dmemload, 32'h0);
    end
  end

  task automatic clear_req();
    bus.dcache_dREN  = 1'b0;
    bus.dcache_dWEN  = 1'b0;
    bus.dcache_daddr = 32'h0;
    bus.dcache_store = 32'h0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    golden = mem;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_req();
    bus.halt = 1'b0;
    @(negedge clk);
    check("rst_dhit", {31'h0, bus.dhit}, 32'h0);
    check("rst_flushed", {31'h0, bus.flushed}, 32'h0);
    check("rst_mem_req", {30'h0, bus.dREN, bus.dWEN}, 32'h0);
    check("rst_outputs", bus.dmemload | bus.daddr | bus.dstore, 32'h0);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // one memory-stage request, held until dhit; starts and ends at posedge+1
  task automatic access(input bit ld, input bit st, input logic [31:0] addr,
                        input logic [31:0] sd, input int w);
    logic [31:0] wa;
    logic [3:0]  idx;
    logic [25:0] tg;
    logic [31:0] vaddr;
    bit          mhit;
    bit          ev;
    int          exp_cyc;
    int          cyc;
    int          wb_before;
    logic [31:0] exp_ld;
    wa   = {addr[31:2], 2'b00};
    idx  = addr[5:2];
    tg   = addr[31:6];
    mhit = m_valid[idx] && (m_tag[idx] == tg);
    ev   = !mhit && m_valid[idx] && m_dirty[idx];
    vaddr   = {m_tag[idx], idx, 2'b00};
    exp_cyc = mhit ? 0 : (ev ? 3 + 2 * w : 2 + w);
    exp_ld  = (ld && !st) ? gold_rd(wa) : 32'h0;
    wait_cycles = w;
    wb_before   = wb_log.size();
    bus.dcache_dREN  = ld;
    bus.dcache_dWEN  = st;
    bus.dcache_daddr = addr;
    bus.dcache_store = sd;
    cyc = 0;
    @(negedge clk);
    while (!bus.dhit && cyc < 100) begin
      if (cyc == 1 && ev) begin
        check("wb_wen", {31'h0, bus.dWEN}, 32'h1);
        check("wb_addr", bus.daddr, vaddr);
        check("wb_data", bus.dstore, gold_rd(vaddr));
      end else if (cyc == 1 && !mhit) begin
        check("fill_ren", {31'h0, bus.dREN}, 32'h1);
        check("fill_addr", bus.daddr, wa);
      end
      cyc++;
      @(negedge clk);
    end
    check("latency", cyc, exp_cyc);
    check("dmemload", bus.dmemload, exp_ld);
    check("wb_count", wb_log.size() - wb_before, ev ? 32'd1 : 32'd0);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    if (st) begin
      m_dirty[idx] = 1'b1;
      golden[wa]   = sd;
    end else if (!mhit) begin
      m_dirty[idx] = 1'b0;
    end
    @(posedge clk);
    #1;
    clear_req();
  endtask

  // halt and expect exactly the model's dirty lines written back in index order
  task automatic do_flush(input int w);
    wb_t exp_q[$];
    int  b;
    int  cyc;
    int  n;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        a = {m_tag[i], 4'(i), 2'b00};
        exp_q.push_back('{a: a, d: gold_rd(a)});
      end
    end
    wait_cycles = w;
    b = wb_log.size();
    bus.halt = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!bus.flushed && cyc < 400) begin
      check("flush_dhit", {31'h0, bus.dhit}, 32'h0);
      cyc++;
      @(negedge clk);
    end
    check("flushed", {31'h0, bus.flushed}, 32'h1);
    n = wb_log.size() - b;
    check("flush_wb_count", n, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      check("flush_wb_addr", wb_log[b + k].a, exp_q[k].a);
      check("flush_wb_data", wb_log[b + k].d, exp_q[k].d);
    end
    for (int i = 0; i < 16; i++) m_dirty[i] = 1'b0;
    // parked: sticky flag, no hits, no memory traffic even with a request
    bus.dcache_dREN  = 1'b1;
    bus.dcache_daddr = exp_q.size() > 0 ? exp_q[0].a : 32'h0;
    repeat (3) begin
      @(negedge clk);
      check("flushed_hold", {31'h0, bus.flushed}, 32'h1);
      check("flushed_nohit", {31'h0, bus.dhit}, 32'h0);
      check("flushed_quiet", {30'h0, bus.dREN, bus.dWEN}, 32'h0);
    end
    clear_req();
  endtask

  initial begin
    int r;
    logic [31:0] a;
    logic [31:0] d;
    rst = 1'b1;
    clear_req();
    bus.halt = 1'b0;
    mem[32'h40] = 32'hDEAD_BEEF;
    do_reset();

    // cold load, two wait cycles: dhit in cycle 4
    access(1'b1, 1'b0, 32'h40, 32'h0, 2);
    // back-to-back hits, then store hit
    access(1'b1, 1'b0, 32'h40, 32'h0, 0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 0);
    access(1'b0, 1'b1, 32'h40, 32'h1234_5678, 0);
    // conflicting load evicts the dirty line first
    access(1'b1, 1'b0, 32'h80, 32'h0, 1);
    check("evict_mem", mem_rd(32'h40), 32'h1234_5678);
    // store miss allocates then completes as a hit
    access(1'b0, 1'b1, 32'hC4, 32'hCAFE_0001, 1);
    access(1'b1, 1'b0, 32'hC4, 32'h0, 0);
    // both enables high behave as a store
    access(1'b1, 1'b1, 32'hC4, 32'hCAFE_0002, 0);
    access(1'b1, 1'b0, 32'hC4, 32'h0, 0);

    // reset in the middle of a fill
    wait_cycles = 6;
    bus.dcache_dREN  = 1'b1;
    bus.dcache_daddr = 32'h1040;
    repeat (3) @(negedge clk);
    check("midfill_ren", {31'h0, bus.dREN}, 32'h1);
    rst = 1'b1;
    #1;
    check("midfill_drop", {30'h0, bus.dREN, bus.dWEN}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_req();
    model_reset();
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'h1040, 32'h0, 1);

    // random traffic over 4 tags x 16 sets
    for (int n = 0; n < 200; n++) begin
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      d = $urandom;
      r = $urandom_range(0, 2);
      access(r != 1, r != 0, a, d, $urandom_range(0, 3));
    end
    do_flush(1);
    for (int i = 0; i < 256; i++) begin
      a = 32'(i) << 2;
      if (golden.exists(a)) check("mem_coherent", mem_rd(a), golden[a]);
    end

    // only lines 0 and 3 dirty: writebacks for 0x00 then 0x0C
    do_reset();
    access(1'b0, 1'b1, 32'h00, 32'h1111_0000, 0);
    access(1'b0, 1'b1, 32'h0C, 32'h3333_0003, 1);
    access(1'b1, 1'b0, 32'h14, 32'h0, 0);
    r = wb_log.size();
    do_flush(2);
    check("flush_n", wb_log.size() - r, 32'd2);
    if (wb_log.size() - r == 2) begin
      check("flush_a0", wb_log[r].a, 32'h0000_0000);
      check("flush_a1", wb_log[r + 1].a, 32'h0000_000C);
      check("flush_d1", wb_log[r + 1].d, 32'h3333_0003);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // overall time bound
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-back, write-allocate data cache that sits directly downstream of the memory stage.
- Consumes the memory stage's dcache request signals (dcache_dREN, dcache_dWEN, dcache_daddr, dcache_store) and returns the hit/ready and load data.
- Issues single-word reads and writes to the memory controller on misses, evictions and the halt-time flush of dirty lines.

Parameters:
- SETS, 16, number of one-word lines; power of two, at least 2; IDX_W = log2(SETS).
- WORD_W, 32, data and address width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- dcache_dREN  input  1  load request from memory stage.
- dcache_dWEN  input  1  store request from memory stage.
- dcache_daddr  input  WORD_W  byte address; bits [1:0] ignored.
- dcache_store  input  WORD_W  store data.
- halt  input  1  CPU halted; triggers flush of dirty lines.
- dhit  output  1  request satisfied this cycle; memory stage may advance.
- dmemload  output  WORD_W  load data, valid when dhit && dcache_dREN.
- flushed  output  1  flush complete; sticky until reset.
- dREN  output  1  memory read request.
- dWEN  output  1  memory write request.
- daddr  output  WORD_W  memory word address, bits [1:0] = 0.
- dstore  output  WORD_W  memory write data.
- dwait  input  1  memory busy; a transfer completes on the first edge where dwait = 0 while dREN or dWEN is high.
- dload  input  WORD_W  memory read data, valid when dwait = 0.

Behaviour:
- Address split: index = daddr[IDX_W+1:2]; tag = daddr[WORD_W-1:IDX_W+2]. Each line holds valid, dirty, tag and data.
- Reset: all valid and dirty bits are cleared and state goes to IDLE. Data and tag arrays need not be cleared. All outputs are 0, including flushed.
- Reset mid-transfer: the transfer is abandoned immediately and dREN/dWEN drop asynchronously.
- Request definition: req = dcache_dREN || dcache_dWEN. If both are high, the request is a store and dmemload is 0.
- Hit: req && valid[index] && tag match, in state IDLE. dhit is combinational in that cycle.
  - A load drives dmemload = data[index].
  - A store writes data[index] = dcache_store and sets dirty at the clock edge.
  - Back-to-back hits are sustained every cycle.
- dhit = 0 in every state other than IDLE. dmemload = 0 whenever dhit = 0.
- States:
  - IDLE: on a miss, go to WB if the victim line is valid and dirty, otherwise go to FILL. If halt && !req, go to FLUSH.
  - WB: dWEN = 1, daddr = {victim tag, index, 2'b00}, dstore = victim data. On completion (dwait = 0), clear dirty and go to FILL.
  - FILL: dREN = 1, daddr = {request tag, index, 2'b00}. On completion, write line: valid = 1, tag = request tag, data = dload, dirty = 0. Then go to IDLE.
    - The request hits in the following cycle; a write miss completes there as a store hit.
  - FLUSH: a scan counter runs from 0 to SETS-1. A line that is valid and dirty is written back as in WB, and the counter advances on completion. A clean line advances the counter in one cycle. After SETS-1 is handled, go to FLUSHED.
  - FLUSHED: flushed = 1, no memory requests, dhit = 0. Exited only by reset.
- Request inputs are sampled continuously, not latched. The memory stage holds them stable until dhit. A change mid-miss produces undefined results.
- Halt during a miss: the miss sequence (WB/FILL) completes first. Halt is honoured in IDLE only when no request is pending.
- Latency, clean miss: miss detected in cycle 0; FILL from cycle 1; with N wait cycles the fill completes at the end of cycle 1+N; dhit in cycle 2+N.
- Latency, dirty miss: adds 1+M cycles for the writeback, where M is its wait cycles.
- Memory outputs are 0 when not in WB, FILL, or a FLUSH writeback. dREN and dWEN are never high together.

Test Plan:
- Cold load at 0x40, dload = 0xDEADBEEF, dwait high for 2 cycles -> FILL with dREN = 1 and daddr = 0x40 from cycle 1; dhit = 1 with dmemload = 0xDEADBEEF in cycle 4.
- Repeat load at 0x40 on consecutive cycles -> dhit = 1 each cycle with no dREN; then store 0x12345678 to 0x40 -> dhit the same cycle, line marked dirty.
- Load at 0x80 (same index 0, new tag) after the dirty store -> dWEN with daddr = 0x40 and dstore = 0x12345678, then dREN with daddr = 0x80, then hit.
- Store miss to 0xC4 (index 1) -> FILL at 0xC4, then store hit; a following load of 0xC4 returns the stored value.
- Lines 0 and 3 dirty, halt asserted with no request -> writebacks occur only for indices 0 and 3, in that order; flushed = 1 after index 15 and held high.
- RST asserted mid-FILL -> dREN drops immediately; after release, a load to the same address misses again.
